md_issue_ctrl: RTL and testbench
================================

Name: md_issue_ctrl

Overview:
- Issue/sequencing stage sitting directly upstream of the multiply/divide unit (multdiv) in the EX stage.
- Accepts MD requests from decode over a valid/ready handshake and registers operands, op, rd address and rd write-enable.
- Holds operands stable for the full duration of a divide and generates the single-cycle div_start pulse.
- Produces the pipeline stall, drops writeback on flush, and drains an in-flight divide that cannot be aborted.

Parameters:
- DIV_TIMEOUT, 40: watchdog limit in cycles for DIV_WAIT. Used only with MD_ISSUE_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- id_md_valid_i  in  1  decode presents an MD request.
- id_md_ready_o  out  1  block can accept a request this cycle.
- id_md_operate_i  in  milano_pkg::md_opt_e  requested operation.
- id_operand_a_i  in  32  rs1 value.
- id_operand_b_i  in  32  rs2 value.
- id_rd_addr_i  in  5  destination register.
- id_rd_we_i  in  1  destination write enable.
- flush_i  in  1  kill the current MD instruction.
- md_operate_o  out  milano_pkg::md_opt_e  registered op to multdiv.
- md_operand_a_o  out  32  registered operand A.
- md_operand_b_o  out  32  registered operand B.
- rd_addr_o  out  5  registered rd address.
- rd_we_o  out  1  registered rd write enable, masked by flush/drain.
- div_start_o  out  1  one-cycle divider start pulse.
- div_done_i  in  1  divider completion from multdiv.
- div_busy_i  in  1  divider busy from multdiv.
- ex_stall_o  out  1  stall upstream pipeline.
- md_done_o  out  1  one-cycle pulse on the cycle the result is written back.
- md_err_o  out  1  sticky timeout error. Tied to 0 without MD_ISSUE_TIMEOUT_EN.

Behaviour:
- Reset: rst_i is synchronous and active-high; clock is clk_i.
  - State goes to IDLE.
  - All registered outputs go to 0: md_operate_o = MD_OP_MUL, operands 0, rd_addr_o 0, rd_we_o 0, div_start_o 0, md_done_o 0, md_err_o 0.
  - Reset mid-divide returns to IDLE immediately without waiting for div_done_i. The divider is reset by the same reset at top level.
- Handshake:
  - A request is accepted when id_md_valid_i && id_md_ready_o.
  - id_md_ready_o = (state == IDLE || state == MUL) && !rst_i.
  - On acceptance, all id_* fields are captured into the output registers.
- Operation classes:
  - MUL-class: MD_OP_MUL, MULH, MULSU, MULU.
  - DIV-class: MD_OP_DIV, DIVU, REM, REMU.
- States:
  - IDLE: accept MUL-class -> MUL; accept DIV-class -> DIV_START.
  - MUL: lasts one cycle; multdiv writes back combinationally; md_done_o = 1. Next state: new MUL-class accept -> MUL; new DIV-class accept -> DIV_START; otherwise IDLE. Back-to-back multiplies sustain 1 per cycle.
  - DIV_START: div_start_o = 1 for exactly this cycle; ex_stall_o = 1. Next state DIV_WAIT.
  - DIV_WAIT: ex_stall_o = 1; operands held. On div_done_i: md_done_o = 1 and next state IDLE.
  - DRAIN: ex_stall_o = 1; rd_we_o = 0. On div_done_i: next state IDLE, md_done_o stays 0.
- Latency:
  - MUL: result is written the cycle after acceptance.
  - DIV: accept at cycle T, div_start_o at T+1, writeback on the div_done_i cycle.
- Flush:
  - In MUL: rd_we_o forced 0 that cycle, md_done_o = 0. A same-cycle accept is ignored.
  - In DIV_START: div_start_o suppressed, next state IDLE.
  - In DIV_WAIT: next state DRAIN. If div_done_i arrives in the same cycle, go to IDLE with the write suppressed.
  - In IDLE: no effect. A flush with a simultaneous valid rejects that request.
- Unexpected inputs:
  - div_done_i outside DIV_WAIT or DRAIN is ignored.
  - div_busy_i asserted in DIV_START is a protocol violation; a bench assertion flags it.

Optional Feature:
- MD_ISSUE_TIMEOUT_EN defined:
  - A 6-bit counter clears on DIV_START and increments each cycle in DIV_WAIT or DRAIN.
  - When the counter reaches DIV_TIMEOUT without div_done_i: md_err_o is set (sticky until reset), rd_we_o is forced 0, next state IDLE.
- Not defined: no counter is built, md_err_o is tied to 0, and the divide is waited on indefinitely.

Test Plan:
- Reset, then MUL request a=7, b=-3 with rd=5 -> one cycle later md_operate_o=MUL, rd_we_o=1, md_done_o=1, ex_stall_o=0.
- Three back-to-back MULU requests -> accepted on consecutive cycles, md_done_o high for 3 consecutive cycles, ready never drops.
- DIV a=100, b=7 accepted at T -> div_start_o high only at T+1; operands stable until div_done_i; md_done_o on the done cycle; ready=0 throughout.
- DIV in DIV_WAIT plus flush_i, then div_done_i 10 cycles later -> DRAIN, rd_we_o=0 on the done cycle, md_done_o=0, back to IDLE the next cycle.
- rst_i asserted during DIV_WAIT -> IDLE the next cycle, all outputs 0, ready=1.
- With MD_ISSUE_TIMEOUT_EN and DIV_TIMEOUT=40, div_done_i withheld -> md_err_o=1 after 40 DIV_WAIT cycles, rd_we_o=0, state IDLE; md_err_o stays set until rst_i.

Source files
------------

// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: issue/sequencing stage in front of the multiply/divide unit.
// Registers an MD request from decode, holds its operands for the whole
// divide, pulses div_start, stalls the pipeline while a divide is in flight
// and drains a flushed divide that the divider cannot abort.
//
// Optional watchdog: define MD_ISSUE_TIMEOUT_EN to build the DIV_WAIT/DRAIN
// timeout counter and the sticky md_err_o flag. Without it md_err_o is 0 and
// a divide is waited on indefinitely.

package milano_pkg;
  typedef enum logic [2:0] {
    MD_OP_MUL   = 3'd0,
    MD_OP_MULH  = 3'd1,
    MD_OP_MULSU = 3'd2,
    MD_OP_MULU  = 3'd3,
    MD_OP_DIV   = 3'd4,
    MD_OP_DIVU  = 3'd5,
    MD_OP_REM   = 3'd6,
    MD_OP_REMU  = 3'd7
  } md_opt_e;
endpackage

module md_issue_ctrl
  import milano_pkg::*;
#(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 id_md_valid_i,
  output logic                 id_md_ready_o,
  input  milano_pkg::md_opt_e  id_md_operate_i,
  input  logic [31:0]          id_operand_a_i,
  input  logic [31:0]          id_operand_b_i,
  input  logic [4:0]           id_rd_addr_i,
  input  logic                 id_rd_we_i,
  input  logic                 flush_i,
  output milano_pkg::md_opt_e  md_operate_o,
  output logic [31:0]          md_operand_a_o,
  output logic [31:0]          md_operand_b_o,
  output logic [4:0]           rd_addr_o,
  output logic                 rd_we_o,
  output logic                 div_start_o,
  input  logic                 div_done_i,
  input  logic                 div_busy_i,
  output logic                 ex_stall_o,
  output logic                 md_done_o,
  output logic                 md_err_o
);

  // state       | meaning
  // S_IDLE      | nothing in flight, ready for a request
  // S_MUL       | multiply writes back this cycle, ready for the next one
  // S_DIV_START | divider start pulse, operands already registered
  // S_DIV_WAIT  | waiting for div_done_i, operands held
  // S_DRAIN     | flushed divide still running, result will be discarded
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MUL       = 3'd1,
    S_DIV_START = 3'd2,
    S_DIV_WAIT  = 3'd3,
    S_DRAIN     = 3'd4
  } state_e;

  state_e state;
  state_e state_next;
  logic   accept;
  logic   tmo_hit;
  logic   we_live;
  logic   rd_we_q;

  // The divider's busy flag is only checked by the bench; the timeout value
  // is only consumed by the optional watchdog.
  logic [31:0] unused_cfg;
  assign unused_cfg = {div_busy_i, 31'(DIV_TIMEOUT)};

  function automatic logic is_div(input md_opt_e op);
    return op inside {MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU};
  endfunction

  assign id_md_ready_o = ((state == S_IDLE) || (state == S_MUL)) && !rst_i;

  // A flush kills any request offered in the same cycle.
  assign accept = id_md_valid_i && id_md_ready_o && !flush_i;

`ifdef MD_ISSUE_TIMEOUT_EN
  logic [5:0] div_cnt;
  logic       err_q;

  // Cycles spent waiting on the divider since the start pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt <= '0;
    end else if (state == S_DIV_START) begin
      div_cnt <= '0;
    end else if ((state == S_DIV_WAIT) || (state == S_DRAIN)) begin
      div_cnt <= div_cnt + 6'd1;
    end
  end

  // Fires on the last permitted waiting cycle so the error is visible right
  // after DIV_TIMEOUT cycles of waiting.
  assign tmo_hit = ((state == S_DIV_WAIT) || (state == S_DRAIN)) && !div_done_i &&
                   (div_cnt == 6'(DIV_TIMEOUT - 1));

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else if (tmo_hit) begin
      err_q <= 1'b1;
    end
  end

  assign md_err_o = err_q;
`else
  assign tmo_hit  = 1'b0;
  assign md_err_o = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and per-state control outputs.
  always_comb begin
    state_next  = state;
    div_start_o = 1'b0;
    md_done_o   = 1'b0;
    ex_stall_o  = 1'b0;
    we_live     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = is_div(id_md_operate_i) ? S_DIV_START : S_MUL;
        end
      end
      S_MUL: begin
        md_done_o = !flush_i;
        we_live   = !flush_i;
        if (accept) begin
          state_next = is_div(id_md_operate_i) ? S_DIV_START : S_MUL;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_DIV_START: begin
        ex_stall_o  = 1'b1;
        div_start_o = !flush_i;
        we_live     = !flush_i;
        state_next  = flush_i ? S_IDLE : S_DIV_WAIT;
      end
      S_DIV_WAIT: begin
        ex_stall_o = 1'b1;
        we_live    = !flush_i && !tmo_hit;
        if (div_done_i) begin
          md_done_o  = !flush_i;
          state_next = S_IDLE;
        end else if (tmo_hit) begin
          state_next = S_IDLE;
        end else if (flush_i) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        ex_stall_o = 1'b1;
        if (div_done_i || tmo_hit) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
    // Nothing may be started or written back while reset is being applied.
    if (rst_i) begin
      div_start_o = 1'b0;
      md_done_o   = 1'b0;
      we_live     = 1'b0;
    end
  end

  // Request capture; fields stay put until the next accepted request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      md_operate_o   <= MD_OP_MUL;
      md_operand_a_o <= '0;
      md_operand_b_o <= '0;
      rd_addr_o      <= '0;
      rd_we_q        <= 1'b0;
    end else if (accept) begin
      md_operate_o   <= id_md_operate_i;
      md_operand_a_o <= id_operand_a_i;
      md_operand_b_o <= id_operand_b_i;
      rd_addr_o      <= id_rd_addr_i;
      rd_we_q        <= id_rd_we_i;
    end
  end

  assign rd_we_o = rd_we_q && we_live;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl: a table of per-cycle vectors for the
// single-cycle behaviour plus hand-written drain, flush and reset sequences.
module tb_md_issue_ctrl;
  import milano_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_md_valid_i;
  logic        id_md_ready_o;
  md_opt_e     id_md_operate_i;
  logic [31:0] id_operand_a_i;
  logic [31:0] id_operand_b_i;
  logic [4:0]  id_rd_addr_i;
  logic        id_rd_we_i;
  logic        flush_i;
  md_opt_e     md_operate_o;
  logic [31:0] md_operand_a_o;
  logic [31:0] md_operand_b_o;
  logic [4:0]  rd_addr_o;
  logic        rd_we_o;
  logic        div_start_o;
  logic        div_done_i;
  logic        div_busy_i;
  logic        ex_stall_o;
  logic        md_done_o;
  logic        md_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  md_issue_ctrl #(.DIV_TIMEOUT(40)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .id_md_valid_i  (id_md_valid_i),
    .id_md_ready_o  (id_md_ready_o),
    .id_md_operate_i(id_md_operate_i),
    .id_operand_a_i (id_operand_a_i),
    .id_operand_b_i (id_operand_b_i),
    .id_rd_addr_i   (id_rd_addr_i),
    .id_rd_we_i     (id_rd_we_i),
    .flush_i        (flush_i),
    .md_operate_o   (md_operate_o),
    .md_operand_a_o (md_operand_a_o),
    .md_operand_b_o (md_operand_b_o),
    .rd_addr_o      (rd_addr_o),
    .rd_we_o        (rd_we_o),
    .div_start_o    (div_start_o),
    .div_done_i     (div_done_i),
    .div_busy_i     (div_busy_i),
    .ex_stall_o     (ex_stall_o),
    .md_done_o      (md_done_o),
    .md_err_o       (md_err_o)
  );

  always #5 clk_i = ~clk_i;

  // The divider must not report busy on the cycle it is being started.
  always @(posedge clk_i) begin
    if (!rst_i && div_start_o) begin
      assert (!div_busy_i) else $error("div_busy_i high during div_start_o");
    end
  end

  typedef struct {
    logic        valid;
    md_opt_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic        flush;
    logic        done;
    logic        e_ready;
    logic        e_stall;
    logic        e_start;
    logic        e_done;
    logic        e_we;
    md_opt_e     e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic valid, input md_opt_e op, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] rd, input logic we,
                     input logic flush, input logic done,
                     input logic e_ready, input logic e_stall, input logic e_start,
                     input logic e_done, input logic e_we, input md_opt_e e_op,
                     input logic [31:0] e_a, input logic [31:0] e_b, input logic [4:0] e_rd);
    vec_t v;
    v.valid = valid; v.op = op; v.a = a; v.b = b; v.rd = rd; v.we = we;
    v.flush = flush; v.done = done;
    v.e_ready = e_ready; v.e_stall = e_stall; v.e_start = e_start;
    v.e_done = e_done; v.e_we = e_we; v.e_op = e_op;
    v.e_a = e_a; v.e_b = e_b; v.e_rd = e_rd;
    vecs.push_back(v);
  endtask

  task automatic idle_in();
    id_md_valid_i   = 1'b0;
    id_md_operate_i = MD_OP_MUL;
    id_operand_a_i  = '0;
    id_operand_b_i  = '0;
    id_rd_addr_i    = '0;
    id_rd_we_i      = 1'b0;
    flush_i         = 1'b0;
    div_done_i      = 1'b0;
    div_busy_i      = 1'b0;
  endtask

  task automatic req(input md_opt_e op, input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic we);
    id_md_valid_i   = 1'b1;
    id_md_operate_i = op;
    id_operand_a_i  = a;
    id_operand_b_i  = b;
    id_rd_addr_i    = rd;
    id_rd_we_i      = we;
  endtask

  task automatic chk_ctl(input string tag, input logic ready, input logic stall,
                         input logic start, input logic done, input logic we);
    chk({tag, ".ready"}, 32'(id_md_ready_o), 32'(ready));
    chk({tag, ".stall"}, 32'(ex_stall_o),    32'(stall));
    chk({tag, ".start"}, 32'(div_start_o),   32'(start));
    chk({tag, ".done"},  32'(md_done_o),     32'(done));
    chk({tag, ".rd_we"}, 32'(rd_we_o),       32'(we));
  endtask

  initial begin
    rst_i = 1'b1;
    idle_in();

    // valid op a b rd we flush done | ready stall start done we | op a b rd
    add(0, MD_OP_MUL,   0,   0, 0, 0, 0, 0,  1,0,0,0,0, MD_OP_MUL,  0,  0, 0);
    add(1, MD_OP_MUL,   7, 32'hFFFF_FFFD, 5, 1, 0, 0,  1,0,0,0,0, MD_OP_MUL, 0, 0, 0);
    add(0, MD_OP_MUL,   0,   0, 0, 0, 0, 0,  1,0,0,1,1, MD_OP_MUL,  7, 32'hFFFF_FFFD, 5);
    add(1, MD_OP_MULU,  1,   2, 1, 1, 0, 0,  1,0,0,0,0, MD_OP_MUL,  7, 32'hFFFF_FFFD, 5);
    add(1, MD_OP_MULU,  3,   4, 2, 1, 0, 0,  1,0,0,1,1, MD_OP_MULU, 1,  2, 1);
    add(1, MD_OP_MULU,  5,   6, 3, 1, 0, 0,  1,0,0,1,1, MD_OP_MULU, 3,  4, 2);
    add(0, MD_OP_MUL,   0,   0, 0, 0, 0, 0,  1,0,0,1,1, MD_OP_MULU, 5,  6, 3);
    add(0, MD_OP_MUL,   0,   0, 0, 0, 0, 0,  1,0,0,0,0, MD_OP_MULU, 5,  6, 3);
    add(1, MD_OP_MUL,   9,   9, 4, 1, 1, 0,  1,0,0,0,0, MD_OP_MULU, 5,  6, 3);
    add(0, MD_OP_MUL,   0,   0, 0, 0, 0, 0,  1,0,0,0,0, MD_OP_MULU, 5,  6, 3);
    add(1, MD_OP_MUL,  11,  12, 4, 1, 0, 0,  1,0,0,0,0, MD_OP_MULU, 5,  6, 3);
    add(1, MD_OP_DIV, 100,   7, 6, 1, 1, 0,  1,0,0,0,0, MD_OP_MUL, 11, 12, 4);
    add(0, MD_OP_MUL,   0,   0, 0, 0, 0, 0,  1,0,0,0,0, MD_OP_MUL, 11, 12, 4);
    add(1, MD_OP_DIV, 100,   7, 6, 1, 0, 0,  1,0,0,0,0, MD_OP_MUL, 11, 12, 4);
    add(1, MD_OP_MUL,  55,  56, 8, 1, 0, 0,  0,1,1,0,1, MD_OP_DIV, 100, 7, 6);
    add(1, MD_OP_MUL,  55,  56, 8, 1, 0, 0,  0,1,0,0,1, MD_OP_DIV, 100, 7, 6);
    add(0, MD_OP_MUL,   0,   0, 0, 0, 0, 0,  0,1,0,0,1, MD_OP_DIV, 100, 7, 6);
    add(0, MD_OP_MUL,   0,   0, 0, 0, 0, 1,  0,1,0,1,1, MD_OP_DIV, 100, 7, 6);
    add(0, MD_OP_MUL,   0,   0, 0, 0, 0, 1,  1,0,0,0,0, MD_OP_DIV, 100, 7, 6);
    add(1, MD_OP_REMU, 32'h8000_0000, 0, 31, 0, 0, 0,  1,0,0,0,0, MD_OP_DIV, 100, 7, 6);
    add(0, MD_OP_MUL,   0,   0, 0, 0, 0, 0,  0,1,1,0,0, MD_OP_REMU, 32'h8000_0000, 0, 31);
    add(0, MD_OP_MUL,   0,   0, 0, 0, 0, 1,  0,1,0,1,0, MD_OP_REMU, 32'h8000_0000, 0, 31);
    add(0, MD_OP_MUL,   0,   0, 0, 0, 0, 0,  1,0,0,0,0, MD_OP_REMU, 32'h8000_0000, 0, 31);
    add(1, MD_OP_MULH,  2,   3, 10, 1, 0, 0, 1,0,0,0,0, MD_OP_REMU, 32'h8000_0000, 0, 31);
    add(1, MD_OP_DIVU, 50,   5, 11, 1, 0, 0, 1,0,0,1,1, MD_OP_MULH, 2, 3, 10);
    add(0, MD_OP_MUL,   0,   0, 0, 0, 0, 0,  0,1,1,0,1, MD_OP_DIVU, 50, 5, 11);
    add(0, MD_OP_MUL,   0,   0, 0, 0, 0, 1,  0,1,0,1,1, MD_OP_DIVU, 50, 5, 11);
    add(0, MD_OP_MUL,   0,   0, 0, 0, 0, 0,  1,0,0,0,0, MD_OP_DIVU, 50, 5, 11);

    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    foreach (vecs[i]) begin
      string tag;
      @(negedge clk_i);
      idle_in();
      if (vecs[i].valid) req(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].we);
      flush_i    = vecs[i].flush;
      div_done_i = vecs[i].done;
      #1;
      tag = $sformatf("v%0d", i);
      chk_ctl(tag, vecs[i].e_ready, vecs[i].e_stall, vecs[i].e_start,
              vecs[i].e_done, vecs[i].e_we);
      chk({tag, ".op"}, 32'(md_operate_o),   32'(vecs[i].e_op));
      chk({tag, ".a"},  md_operand_a_o,      vecs[i].e_a);
      chk({tag, ".b"},  md_operand_b_o,      vecs[i].e_b);
      chk({tag, ".rd"}, 32'(rd_addr_o),      32'(vecs[i].e_rd));
      chk({tag, ".err"}, 32'(md_err_o),      32'd0);
    end

    // Flush during DIV_WAIT, divider finishes 10 cycles later in DRAIN.
    @(negedge clk_i); idle_in(); req(MD_OP_DIV, 200, 3, 7, 1); #1;
    chk_ctl("drain.accept", 1, 0, 0, 0, 0);
    @(negedge clk_i); idle_in(); #1;
    chk_ctl("drain.start", 0, 1, 1, 0, 1);
    @(negedge clk_i); idle_in(); flush_i = 1'b1; div_busy_i = 1'b1; #1;
    chk_ctl("drain.flush", 0, 1, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_i); idle_in(); div_busy_i = 1'b1; #1;
      chk_ctl($sformatf("drain.wait%0d", k), 0, 1, 0, 0, 0);
      chk($sformatf("drain.a%0d", k), md_operand_a_o, 32'd200);
    end
    @(negedge clk_i); idle_in(); div_done_i = 1'b1; #1;
    chk_ctl("drain.done", 0, 1, 0, 0, 0);
    @(negedge clk_i); idle_in(); #1;
    chk_ctl("drain.idle", 1, 0, 0, 0, 0);

    // Flush in DIV_START suppresses the start pulse and returns to IDLE.
    @(negedge clk_i); idle_in(); req(MD_OP_REM, 8, 2, 3, 1); #1;
    @(negedge clk_i); idle_in(); flush_i = 1'b1; #1;
    chk_ctl("fstart", 0, 1, 0, 0, 0);
    @(negedge clk_i); idle_in(); #1;
    chk_ctl("fstart.idle", 1, 0, 0, 0, 0);

    // Flush together with div_done in DIV_WAIT: straight to IDLE, no write.
    @(negedge clk_i); idle_in(); req(MD_OP_DIV, 9, 3, 4, 1); #1;
    @(negedge clk_i); idle_in(); #1;
    chk_ctl("fdone.start", 0, 1, 1, 0, 1);
    @(negedge clk_i); idle_in(); flush_i = 1'b1; div_done_i = 1'b1; #1;
    chk_ctl("fdone.wait", 0, 1, 0, 0, 0);
    @(negedge clk_i); idle_in(); #1;
    chk_ctl("fdone.idle", 1, 0, 0, 0, 0);

    // Reset in the middle of a divide.
    @(negedge clk_i); idle_in(); req(MD_OP_DIVU, 300, 5, 9, 1); #1;
    @(negedge clk_i); idle_in(); #1;
    @(negedge clk_i); idle_in(); #1;
    chk_ctl("rst.wait", 0, 1, 0, 0, 1);
    @(negedge clk_i); idle_in(); rst_i = 1'b1; #1;
    chk("rst.ready_in_reset", 32'(id_md_ready_o), 32'd0);
    @(negedge clk_i); rst_i = 1'b0; #1;
    chk_ctl("rst.after", 1, 0, 0, 0, 0);
    chk("rst.op",  32'(md_operate_o), 32'(MD_OP_MUL));
    chk("rst.a",   md_operand_a_o,    32'd0);
    chk("rst.b",   md_operand_b_o,    32'd0);
    chk("rst.rd",  32'(rd_addr_o),    32'd0);
    chk("rst.err", 32'(md_err_o),     32'd0);
    @(negedge clk_i); idle_in(); div_done_i = 1'b1; #1;
    chk_ctl("rst.stray_done", 1, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
